// File: rtl/dlsc_pcie_s6_inbound_cpl.sv
// Completion TLP builder for the inbound read path. Merges per-completion
// headers, per-request routing info and read data into 32-bit Cpl/CplD TLPs.
// Unsuccessful completions go out as a data-less Cpl; their data is drained.
module dlsc_pcie_s6_inbound_cpl #(
  parameter bit UR_ON_DECERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] completer_id,
  output logic        req_i_ready,
  input  logic        req_i_valid,
  input  logic [15:0] req_i_id,
  input  logic [7:0]  req_i_tag,
  input  logic [2:0]  req_i_tc,
  input  logic [1:0]  req_i_attr,
  output logic        cpl_h_ready,
  input  logic        cpl_h_valid,
  input  logic [6:0]  cpl_h_addr,
  input  logic [9:0]  cpl_h_len,
  input  logic [11:0] cpl_h_bytes,
  input  logic        cpl_h_last,
  input  logic [1:0]  cpl_h_resp,
  output logic        cpl_d_ready,
  input  logic        cpl_d_valid,
  input  logic [31:0] cpl_d_data,
  input  logic        cpl_d_last,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic        tx_last,
  output logic        err_mismatch
);

  typedef enum logic [2:0] {
    StIdle,
    StH0,
    StH1,
    StH2,
    StData,
    StDrop
  } state_e;

  state_e state_q, state_d;

  // Captured header and routing fields
  logic [6:0]  addr_q;
  logic [9:0]  len_q;
  logic [11:0] bytes_q;
  logic [2:0]  status_q;
  logic [15:0] req_id_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [15:0] cid_q;

  logic [10:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        tx_valid_q, tx_valid_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic        tx_last_q, tx_last_d;

  logic [2:0]  status_in;
  logic        ok;
  logic [10:0] len_full;
  logic [10:0] cnt_inc;
  logic        cnt_hit;
  logic        load;
  logic        h_fire;
  logic        d_fire;
  logic        tx_load;
  logic [31:0] tx_word;
  logic        tx_word_last;
  logic [9:0]  len_field;
  logic [31:0] dw0, dw1, dw2;

  // AXI response to completion status
  always_comb begin
    case (cpl_h_resp)
      2'b11:   status_in = UR_ON_DECERR ? 3'b001 : 3'b100;
      2'b10:   status_in = 3'b100;
      default: status_in = 3'b000;
    endcase
  end

  assign ok        = (status_q == 3'b000);
  // A length of 0 encodes 1024 DW
  assign len_full  = {(len_q == 10'd0), len_q};
  assign cnt_inc   = cnt_q + 11'd1;
  assign cnt_hit   = (cnt_inc == len_full);
  assign load      = !tx_valid_q || tx_ready;

  assign cpl_h_ready = (state_q == StIdle) && req_i_valid;
  assign h_fire      = cpl_h_ready && cpl_h_valid;
  // Request info is only peeked for split completions; pop on the final one
  assign req_i_ready = h_fire && cpl_h_last;
  assign cpl_d_ready = (state_q == StData) ? load : (state_q == StDrop);
  assign d_fire      = cpl_d_ready && cpl_d_valid;

  assign len_field = ok ? len_q : 10'd0;
  assign dw0 = {1'b0, (ok ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc_q, 4'b0000,
                1'b0, 1'b0, attr_q, 2'b00, len_field};
  assign dw1 = {cid_q, status_q, 1'b0, bytes_q};
  assign dw2 = {req_id_q, tag_q, 1'b0, addr_q};

  // Next-state, word counter, mismatch flag and output-register loading
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    tx_load      = 1'b0;
    tx_word      = '0;
    tx_word_last = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (h_fire) begin
          state_d = StH0;
          cnt_d   = '0;
        end
      end
      StH0: begin
        if (load) begin
          tx_load = 1'b1;
          tx_word = dw0;
          state_d = StH1;
        end
      end
      StH1: begin
        if (load) begin
          tx_load = 1'b1;
          tx_word = dw1;
          state_d = StH2;
        end
      end
      StH2: begin
        if (load) begin
          tx_load      = 1'b1;
          tx_word      = dw2;
          tx_word_last = !ok;
          state_d      = ok ? StData : StDrop;
        end
      end
      StData, StDrop: begin
        if (d_fire) begin
          if (state_q == StData) begin
            tx_load      = 1'b1;
            tx_word      = cpl_d_data;
            tx_word_last = cnt_hit;
          end
          cnt_d = cnt_inc;
          if (cpl_d_last != cnt_hit) begin
            err_d = 1'b1;
          end
          // The length count, not cpl_d_last, ends the completion
          if (cnt_hit) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    if (tx_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = tx_word;
      tx_last_d  = tx_word_last;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // State, counter, sticky error and transmit register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

  // Header, routing info and completer ID capture on the header handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      len_q    <= '0;
      bytes_q  <= '0;
      status_q <= '0;
      req_id_q <= '0;
      tag_q    <= '0;
      tc_q     <= '0;
      attr_q   <= '0;
      cid_q    <= '0;
    end else if (h_fire) begin
      addr_q   <= cpl_h_addr;
      len_q    <= cpl_h_len;
      bytes_q  <= cpl_h_bytes;
      status_q <= status_in;
      req_id_q <= req_i_id;
      tag_q    <= req_i_tag;
      tc_q     <= req_i_tc;
      attr_q   <= req_i_attr;
      cid_q    <= completer_id;
    end
  end

  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign tx_last      = tx_last_q;
  assign err_mismatch = err_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_cpl.sv
// Self-checking bench: randomized sources feed the completion builder; a
// transaction-level model predicts every TLP word and the error flag.
module tb_dlsc_pcie_s6_inbound_cpl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] completer_id;
  logic        req_i_ready, req_i_valid;
  logic [15:0] req_i_id;
  logic [7:0]  req_i_tag;
  logic [2:0]  req_i_tc;
  logic [1:0]  req_i_attr;
  logic        cpl_h_ready, cpl_h_valid;
  logic [6:0]  cpl_h_addr;
  logic [9:0]  cpl_h_len;
  logic [11:0] cpl_h_bytes;
  logic        cpl_h_last;
  logic [1:0]  cpl_h_resp;
  logic        cpl_d_ready, cpl_d_valid;
  logic [31:0] cpl_d_data;
  logic        cpl_d_last;
  logic        tx_ready, tx_valid, tx_last, err_mismatch;
  logic [31:0] tx_data;

  always #5 clk = ~clk;

  dlsc_pcie_s6_inbound_cpl #(.UR_ON_DECERR(1'b1)) dut (
    .clk(clk), .rst(rst), .completer_id(completer_id),
    .req_i_ready(req_i_ready), .req_i_valid(req_i_valid), .req_i_id(req_i_id),
    .req_i_tag(req_i_tag), .req_i_tc(req_i_tc), .req_i_attr(req_i_attr),
    .cpl_h_ready(cpl_h_ready), .cpl_h_valid(cpl_h_valid), .cpl_h_addr(cpl_h_addr),
    .cpl_h_len(cpl_h_len), .cpl_h_bytes(cpl_h_bytes), .cpl_h_last(cpl_h_last),
    .cpl_h_resp(cpl_h_resp), .cpl_d_ready(cpl_d_ready), .cpl_d_valid(cpl_d_valid),
    .cpl_d_data(cpl_d_data), .cpl_d_last(cpl_d_last), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .err_mismatch(err_mismatch)
  );

  typedef struct {
    logic [15:0] id; logic [7:0] tag; logic [2:0] tc; logic [1:0] attr;
  } req_t;
  typedef struct {
    logic [6:0] addr; logic [9:0] len; logic [11:0] bytes; logic last;
    logic [1:0] resp; logic [15:0] cid;
  } hdr_t;
  typedef struct { logic [31:0] data; logic last; logic bad; } dat_t;
  typedef struct { logic [31:0] data; logic last; } word_t;

  req_t  r_q[$];
  hdr_t  h_q[$];
  dat_t  d_q[$];
  word_t exp_q[$];
  req_t  cur_r;
  hdr_t  cur_h;
  dat_t  cur_d;

  bit h_fire, r_fire, d_fire, exp_err;
  bit src_en;
  int unsigned h_gap, d_gap;
  int txr_mode, pcnt;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] acc_w[$];
  logic        acc_l[$];
  int          acc_c[$];
  int          hdr_c[$];
  int          r_pops, d_pops;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic push_req(input req_t r);
    r_q.push_back(r);
  endtask

  // Model: one completion header expands into the words the TLP must carry
  task automatic push_cpl(input req_t r, input hdr_t h, input int mis_pos,
                          input logic [31:0] dbase);
    int n;
    logic [31:0] st, dw0, dw1, dw2, dv;
    bit ok, lf;
    n  = (h.len == 10'd0) ? 1024 : int'(h.len);
    st = (h.resp == 2'b11) ? 32'd1 : ((h.resp == 2'b10) ? 32'd4 : 32'd0);
    ok = (st == 32'd0);
    dw0 = (ok ? 32'h4A00_0000 : 32'h0A00_0000) + (32'(r.tc) << 20) + (32'(r.attr) << 12)
          + (ok ? 32'(h.len) : 32'd0);
    dw1 = (32'(h.cid) << 16) + (st << 13) + 32'(h.bytes);
    dw2 = (32'(r.id) << 16) + (32'(r.tag) << 8) + 32'(h.addr);
    h_q.push_back(h);
    exp_q.push_back('{dw0, 1'b0});
    exp_q.push_back('{dw1, 1'b0});
    exp_q.push_back('{dw2, !ok});
    for (int i = 1; i <= n; i++) begin
      dv = (dbase != 32'd0) ? dbase + 32'(i - 1) : $urandom;
      lf = (mis_pos == 0) ? (i == n) : (i == mis_pos);
      d_q.push_back('{dv, lf, (lf != (i == n))});
      if (ok) exp_q.push_back('{dv, (i == n)});
    end
  endtask

  task automatic clear_log();
    acc_w.delete(); acc_l.delete(); acc_c.delete(); hdr_c.delete();
    r_pops = 0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      done = (exp_q.size() == 0) && (h_q.size() == 0) && (d_q.size() == 0) &&
             (r_q.size() == 0) && !cpl_d_valid && !cpl_h_valid && !req_i_valid;
    end
    repeat (3) @(posedge clk);
    check(name, 32'(done), 32'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1; src_en = 1'b0;
    h_q.delete(); d_q.delete(); r_q.delete(); exp_q.delete();
    cpl_h_valid = 1'b0; cpl_d_valid = 1'b0; req_i_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0; src_en = 1'b1;
  endtask

  initial forever @(posedge clk) cyc++;

  // Header source
  initial forever begin
    @(posedge clk); #1;
    if (!src_en) cpl_h_valid = 1'b0;
    else if (!cpl_h_valid || h_fire) begin
      if (h_q.size() > 0 && $urandom_range(0, 99) >= h_gap) begin
        cur_h = h_q.pop_front();
        cpl_h_valid = 1'b1; cpl_h_addr = cur_h.addr; cpl_h_len = cur_h.len;
        cpl_h_bytes = cur_h.bytes; cpl_h_last = cur_h.last; cpl_h_resp = cur_h.resp;
        completer_id = cur_h.cid;
      end else begin
        cpl_h_valid = 1'b0; completer_id = 16'($urandom);
        cpl_h_len = 10'($urandom); cpl_h_resp = 2'($urandom);
      end
    end
  end

  // Request-info source
  initial forever begin
    @(posedge clk); #1;
    if (!src_en) req_i_valid = 1'b0;
    else if (!req_i_valid || r_fire) begin
      if (r_q.size() > 0) begin
        cur_r = r_q.pop_front();
        req_i_valid = 1'b1; req_i_id = cur_r.id; req_i_tag = cur_r.tag;
        req_i_tc = cur_r.tc; req_i_attr = cur_r.attr;
      end else begin
        req_i_valid = 1'b0;
      end
    end
  end

  // Data source
  initial forever begin
    @(posedge clk); #1;
    if (!src_en) cpl_d_valid = 1'b0;
    else if (!cpl_d_valid || d_fire) begin
      if (d_q.size() > 0 && $urandom_range(0, 99) >= d_gap) begin
        cur_d = d_q.pop_front();
        cpl_d_valid = 1'b1; cpl_d_data = cur_d.data; cpl_d_last = cur_d.last;
      end else begin
        cpl_d_valid = 1'b0; cpl_d_data = $urandom;
      end
    end
  end

  // Downstream ready: 0 random, 1 always, 2 pattern 1,0,0,1, 3 driven by the test
  initial forever begin
    @(posedge clk); #1;
    case (txr_mode)
      0: tx_ready = ($urandom_range(0, 3) != 0);
      1: tx_ready = 1'b1;
      2: begin tx_ready = pat[pcnt % 4]; pcnt++; end
      default: ;
    endcase
  end

  // Compare process: handshakes, TLP words, stall stability, error flag
  initial begin
    bit stall;
    logic [31:0] prev_d;
    logic prev_l;
    word_t w;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_fire = 1'b0; r_fire = 1'b0; d_fire = 1'b0; stall = 1'b0; exp_err = 1'b0;
      end else begin
        check("err_mismatch", 32'(err_mismatch), 32'(exp_err));
        h_fire = cpl_h_valid && cpl_h_ready;
        r_fire = req_i_valid && req_i_ready;
        d_fire = cpl_d_valid && cpl_d_ready;
        if (h_fire) hdr_c.push_back(cyc);
        if (h_fire || r_fire) check("req_pop_rule", 32'(r_fire), 32'(h_fire && cur_h.last));
        if (r_fire) r_pops++;
        if (d_fire) begin
          d_pops++;
          if (cur_d.bad) exp_err = 1'b1;
        end
        if (stall) begin
          check("stall_valid", 32'(tx_valid), 32'd1);
          check("stall_data", tx_data, prev_d);
          check("stall_last", 32'(tx_last), 32'(prev_l));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL tx_extra: got word %h, required no word", tx_data);
          end else begin
            w = exp_q.pop_front();
            check("tx_data", tx_data, w.data);
            check("tx_last", 32'(tx_last), 32'(w.last));
          end
          acc_w.push_back(tx_data); acc_l.push_back(tx_last); acc_c.push_back(cyc);
        end
        stall = tx_valid && !tx_ready;
        prev_d = tx_data; prev_l = tx_last;
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    hdr_t h;
    int d0, k, nreq;
    rst = 1'b1; src_en = 1'b0; txr_mode = 1; pcnt = 0; h_gap = 0; d_gap = 0;
    tx_ready = 1'b1; completer_id = '0;
    req_i_valid = 1'b0; req_i_id = '0; req_i_tag = '0; req_i_tc = '0; req_i_attr = '0;
    cpl_h_valid = 1'b0; cpl_h_addr = '0; cpl_h_len = '0; cpl_h_bytes = '0;
    cpl_h_last = 1'b0; cpl_h_resp = '0;
    cpl_d_valid = 1'b0; cpl_d_data = '0; cpl_d_last = 1'b0;
    d_pops = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_err", 32'(err_mismatch), 32'd0);
    check("rst_d_ready", 32'(cpl_d_ready), 32'd0);
    rst = 1'b0; src_en = 1'b1;
    @(posedge clk);

    // Single CplD with literal expectations and latency
    clear_log();
    r = '{16'h0100, 8'h05, 3'd0, 2'd0};
    push_req(r);
    push_cpl(r, '{7'h10, 10'd4, 12'd16, 1'b1, 2'b00, 16'h0200}, 0, 32'hA0);
    wait_drain(200, "single_drain");
    check("single_nwords", 32'(acc_w.size()), 32'd7);
    if (acc_w.size() == 7) begin
      check("single_dw0", acc_w[0], 32'h4A00_0004);
      check("single_dw1", acc_w[1], 32'h0200_0010);
      check("single_dw2", acc_w[2], 32'h0100_0510);
      check("single_d3", acc_w[6], 32'h0000_00A3);
      check("single_last", 32'(acc_l[6] && !acc_l[5] && !acc_l[2]), 32'd1);
      check("single_lat", 32'(acc_c[0] - hdr_c[0]), 32'd2);
      check("single_tput", 32'(acc_c[6] - acc_c[0]), 32'd6);
    end
    check("single_req_pops", 32'(r_pops), 32'd1);

    // Back-to-back CplDs: one idle bubble between TLPs
    clear_log();
    r = '{16'h0A0B, 8'h11, 3'd2, 2'd1};
    push_req(r);
    push_cpl(r, '{7'h04, 10'd2, 12'd8, 1'b1, 2'b00, 16'h0300}, 0, 32'd0);
    r = '{16'h0C0D, 8'h12, 3'd5, 2'd2};
    push_req(r);
    push_cpl(r, '{7'h08, 10'd2, 12'd8, 1'b1, 2'b00, 16'h0301}, 0, 32'd0);
    wait_drain(200, "b2b_drain");
    check("b2b_nwords", 32'(acc_w.size()), 32'd10);
    if (acc_w.size() == 10 && hdr_c.size() == 2) begin
      check("b2b_hdr_accept", 32'(hdr_c[1] - acc_c[4]), 32'd0);
      check("b2b_bubble", 32'(acc_c[5] - acc_c[4]), 32'd2);
    end

    // Split request: two completions share one request entry
    clear_log();
    txr_mode = 0;
    r = '{16'h2233, 8'h7C, 3'd1, 2'd3};
    push_req(r);
    push_cpl(r, '{7'h00, 10'd32, 12'd256, 1'b0, 2'b00, 16'h0400}, 0, 32'd0);
    push_cpl(r, '{7'h00, 10'd32, 12'd128, 1'b1, 2'b00, 16'h0400}, 0, 32'd0);
    wait_drain(2000, "split_drain");
    check("split_req_pops", 32'(r_pops), 32'd1);
    check("split_nwords", 32'(acc_w.size()), 32'd70);
    if (acc_w.size() == 70) begin
      check("split_tag1", 32'(acc_w[2][15:8]), 32'h7C);
      check("split_tag2", 32'(acc_w[37][15:8]), 32'h7C);
    end

    // DECERR: data-less Cpl, data drained while DW2 is stalled
    clear_log();
    txr_mode = 3; tx_ready = 1'b1;
    d0 = d_pops;
    r = '{16'h1234, 8'h22, 3'd0, 2'd0};
    push_req(r);
    push_cpl(r, '{7'h08, 10'd2, 12'd8, 1'b1, 2'b11, 16'h0500}, 0, 32'd0);
    k = 0;
    while (acc_w.size() < 2 && k < 100) begin @(posedge clk); k++; end
    #2 tx_ready = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("decerr_drained", 32'(d_pops - d0), 32'd2);
    check("decerr_hold_valid", 32'(tx_valid), 32'd1);
    check("decerr_hold_dw2", tx_data, 32'h1234_2208);
    check("decerr_hold_last", 32'(tx_last), 32'd1);
    tx_ready = 1'b1;
    wait_drain(200, "decerr_drain");
    check("decerr_nwords", 32'(acc_w.size()), 32'd3);
    if (acc_w.size() == 3) begin
      check("decerr_dw0", acc_w[0], 32'h0A00_0000);
      check("decerr_status", 32'(acc_w[1][15:13]), 32'd1);
    end

    // Backpressure with tx_ready 1,0,0,1
    clear_log();
    txr_mode = 2; pcnt = 0;
    r = '{16'h5566, 8'h33, 3'd3, 2'd1};
    push_req(r);
    push_cpl(r, '{7'h1C, 10'd4, 12'd16, 1'b1, 2'b00, 16'h0600}, 0, 32'd0);
    wait_drain(300, "bp_drain");
    check("bp_nwords", 32'(acc_w.size()), 32'd7);

    // Length mismatch: flag sets and persists, length count ends the TLP
    clear_log();
    txr_mode = 1;
    r = '{16'h7788, 8'h44, 3'd0, 2'd0};
    push_req(r);
    push_cpl(r, '{7'h00, 10'd3, 12'd12, 1'b1, 2'b00, 16'h0700}, 2, 32'd0);
    wait_drain(200, "mis_drain");
    check("mis_nwords", 32'(acc_w.size()), 32'd6);
    check("mis_flag", 32'(err_mismatch), 32'd1);
    r = '{16'h7789, 8'h45, 3'd0, 2'd0};
    push_req(r);
    push_cpl(r, '{7'h00, 10'd1, 12'd4, 1'b1, 2'b00, 16'h0700}, 0, 32'd0);
    wait_drain(200, "mis_persist_drain");
    check("mis_persist", 32'(err_mismatch), 32'd1);

    // Reset in the middle of a TLP
    clear_log();
    r = '{16'h99AA, 8'h55, 3'd0, 2'd0};
    push_req(r);
    push_cpl(r, '{7'h00, 10'd4, 12'd16, 1'b1, 2'b00, 16'h0800}, 0, 32'd0);
    k = 0;
    while (acc_w.size() < 1 && k < 100) begin @(posedge clk); k++; end
    apply_reset();
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_err", 32'(err_mismatch), 32'd0);
    clear_log();
    r = '{16'h99AB, 8'h56, 3'd1, 2'd1};
    push_req(r);
    push_cpl(r, '{7'h20, 10'd4, 12'd16, 1'b1, 2'b00, 16'h0801}, 0, 32'd0);
    wait_drain(200, "postrst_drain");
    check("postrst_nwords", 32'(acc_w.size()), 32'd7);

    // Randomized traffic against the model
    txr_mode = 0; h_gap = 20; d_gap = 25;
    nreq = 40;
    for (int i = 0; i < nreq; i++) begin
      r = '{16'($urandom), 8'($urandom), 3'($urandom), 2'($urandom)};
      push_req(r);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        h.addr = 7'($urandom); h.bytes = 12'($urandom); h.cid = 16'($urandom);
        h.last = (j == k - 1);
        h.len = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom_range(1, 8));
        case ($urandom_range(0, 5))
          4: h.resp = 2'b10;
          5: h.resp = 2'b11;
          default: h.resp = 2'b00;
        endcase
        push_cpl(r, h, 0, 32'd0);
      end
    end
    wait_drain(50000, "random_drain");
    check("random_no_err", 32'(err_mismatch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
